// File: rtl/rv32_ctrl_alu_exmem.sv
// RV32I slice: ID-stage control decoder, EX-stage ALU and the EX/MEM pipeline register.
// Decoder and ALU are combinational; only the EX/MEM register uses clk/rst.
module rv32_ctrl_alu_exmem (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic        stall,
  output logic [3:0]  alu_op,
  output logic        MR,
  output logic        MW,
  output logic        MemtoReg,
  output logic        regWE,
  output logic        aluSrc,
  output logic        beq,
  output logic        bneq,
  output logic        blt,
  output logic        bge,
  output logic        jmp,
  output logic        jalr,
  input  logic [3:0]  ex_alu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  input  logic        MR_in,
  input  logic        MW_in,
  input  logic        MemtoReg_in,
  input  logic        jmp_in,
  input  logic        regWE_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] rout2_in,
  input  logic [31:0] pc_in,
  output logic        MR_out,
  output logic        MW_out,
  output logic        MemtoReg_out,
  output logic        jmp_out,
  output logic        regWE_out,
  output logic [4:0]  rd_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] rout2_out,
  output logic [31:0] pc_out
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_PASS = 4'b1010;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  logic [3:0] f3_op;
  logic       unused_func7;

  // Only func7[5] distinguishes SUB/SRA; the other bits are don't-care here.
  assign unused_func7 = ^{func7[6], func7[4:0]};

  // funct3 -> ALU op shared by R-type and I-ALU; SUB is handled per opcode.
  always_comb begin
    f3_op = OP_ADD;
    case (func3)
      3'b000: f3_op = OP_ADD;
      3'b001: f3_op = OP_SLL;
      3'b010: f3_op = OP_SLT;
      3'b011: f3_op = OP_SLTU;
      3'b100: f3_op = OP_XOR;
      3'b101: f3_op = func7[5] ? OP_SRA : OP_SRL;
      3'b110: f3_op = OP_OR;
      3'b111: f3_op = OP_AND;
      default: f3_op = OP_ADD;
    endcase
  end

  always_comb begin
    alu_op   = OP_ADD;
    MR       = 1'b0;
    MW       = 1'b0;
    MemtoReg = 1'b0;
    regWE    = 1'b0;
    aluSrc   = 1'b0;
    beq      = 1'b0;
    bneq     = 1'b0;
    blt      = 1'b0;
    bge      = 1'b0;
    jmp      = 1'b0;
    jalr     = 1'b0;
    // A stall bubble leaves every control at its default.
    if (!stall) begin
      case (opcode)
        OPC_R: begin
          regWE  = 1'b1;
          alu_op = (func3 == 3'b000 && func7[5]) ? OP_SUB : f3_op;
        end
        OPC_I: begin
          regWE  = 1'b1;
          aluSrc = 1'b1;
          alu_op = f3_op;
        end
        OPC_LOAD: begin
          MR       = 1'b1;
          MemtoReg = 1'b1;
          regWE    = 1'b1;
          aluSrc   = 1'b1;
        end
        OPC_STORE: begin
          MW     = 1'b1;
          aluSrc = 1'b1;
        end
        OPC_BRANCH: begin
          alu_op = OP_SUB;
          case (func3)
            3'b000:  beq  = 1'b1;
            3'b001:  bneq = 1'b1;
            3'b100:  blt  = 1'b1;
            3'b101:  bge  = 1'b1;
            default: ;
          endcase
        end
        OPC_JAL: begin
          jmp   = 1'b1;
          regWE = 1'b1;
        end
        OPC_JALR: begin
          jalr   = 1'b1;
          regWE  = 1'b1;
          aluSrc = 1'b1;
        end
        OPC_LUI: begin
          regWE  = 1'b1;
          aluSrc = 1'b1;
          alu_op = OP_PASS;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Result = A + B;
    case (ex_alu_op)
      OP_ADD:  Result = A + B;
      OP_SUB:  Result = A - B;
      OP_AND:  Result = A & B;
      OP_OR:   Result = A | B;
      OP_XOR:  Result = A ^ B;
      OP_SLL:  Result = A << B[4:0];
      OP_SRL:  Result = A >> B[4:0];
      OP_SRA:  Result = $unsigned($signed(A) >>> B[4:0]);
      OP_SLT:  Result = {31'b0, $signed(A) < $signed(B)};
      OP_SLTU: Result = {31'b0, A < B};
      OP_PASS: Result = B;
      default: Result = A + B;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      MR_out         <= 1'b0;
      MW_out         <= 1'b0;
      MemtoReg_out   <= 1'b0;
      jmp_out        <= 1'b0;
      regWE_out      <= 1'b0;
      rd_out         <= 5'b0;
      alu_result_out <= 32'b0;
      rout2_out      <= 32'b0;
      pc_out         <= 32'b0;
    end else begin
      MR_out         <= MR_in;
      MW_out         <= MW_in;
      MemtoReg_out   <= MemtoReg_in;
      jmp_out        <= jmp_in;
      regWE_out      <= regWE_in;
      rd_out         <= rd_in;
      alu_result_out <= Result;
      rout2_out      <= rout2_in;
      pc_out         <= pc_in;
    end
  end

endmodule

// File: tb/tb_rv32_ctrl_alu_exmem.sv
// Bench for rv32_ctrl_alu_exmem: directed literal cases plus randomized traffic
// compared every cycle against an in-bench decode/ALU/pipeline model.
module tb_rv32_ctrl_alu_exmem;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        stall;
  logic [3:0]  alu_op;
  logic        MR, MW, MemtoReg, regWE, aluSrc;
  logic        beq, bneq, blt, bge, jmp, jalr;
  logic [3:0]  ex_alu_op;
  logic [31:0] A, B, Result;
  logic        MR_in, MW_in, MemtoReg_in, jmp_in, regWE_in;
  logic [4:0]  rd_in;
  logic [31:0] rout2_in, pc_in;
  logic        MR_out, MW_out, MemtoReg_out, jmp_out, regWE_out;
  logic [4:0]  rd_out;
  logic [31:0] alu_result_out, rout2_out, pc_out;

  int checks = 0;
  int failures = 0;
  logic [105:0] exp_q[$];

  rv32_ctrl_alu_exmem dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .stall(stall),
    .alu_op(alu_op), .MR(MR), .MW(MW), .MemtoReg(MemtoReg), .regWE(regWE), .aluSrc(aluSrc),
    .beq(beq), .bneq(bneq), .blt(blt), .bge(bge), .jmp(jmp), .jalr(jalr),
    .ex_alu_op(ex_alu_op), .A(A), .B(B), .Result(Result),
    .MR_in(MR_in), .MW_in(MW_in), .MemtoReg_in(MemtoReg_in), .jmp_in(jmp_in), .regWE_in(regWE_in),
    .rd_in(rd_in), .rout2_in(rout2_in), .pc_in(pc_in),
    .MR_out(MR_out), .MW_out(MW_out), .MemtoReg_out(MemtoReg_out), .jmp_out(jmp_out),
    .regWE_out(regWE_out), .rd_out(rd_out), .alu_result_out(alu_result_out),
    .rout2_out(rout2_out), .pc_out(pc_out)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wire [14:0]  dut_dec = {alu_op, MR, MW, MemtoReg, regWE, aluSrc, beq, bneq, blt, bge, jmp, jalr};
  wire [105:0] dut_pipe = {MR_out, MW_out, MemtoReg_out, jmp_out, regWE_out, rd_out,
                           alu_result_out, rout2_out, pc_out};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode model: {alu_op, MR, MW, MemtoReg, regWE, aluSrc, beq, bneq, blt, bge, jmp, jalr}
  function automatic logic [14:0] dec_model(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic st);
    logic [3:0] f3_map[8];
    logic [3:0] a;
    logic mr, mw, m2r, we, src, fbeq, fbne, fblt, fbge, fj, fjr;
    f3_map = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    a = 4'd0;
    {mr, mw, m2r, we, src, fbeq, fbne, fblt, fbge, fj, fjr} = '0;
    if (!st) begin
      if (op == 7'h33 || op == 7'h13) begin
        we = 1'b1;
        src = (op == 7'h13);
        a = f3_map[f3];
        if (f3 == 3'd5 && f7[5]) a = 4'd7;
        if (op == 7'h33 && f3 == 3'd0 && f7[5]) a = 4'd1;
      end else if (op == 7'h03) begin
        mr = 1; m2r = 1; we = 1; src = 1;
      end else if (op == 7'h23) begin
        mw = 1; src = 1;
      end else if (op == 7'h63) begin
        a = 4'd1;
        fbeq = (f3 == 3'd0); fbne = (f3 == 3'd1); fblt = (f3 == 3'd4); fbge = (f3 == 3'd5);
      end else if (op == 7'h6F) begin
        fj = 1; we = 1;
      end else if (op == 7'h67) begin
        fjr = 1; we = 1; src = 1;
      end else if (op == 7'h37) begin
        we = 1; src = 1; a = 4'd10;
      end
    end
    return {a, mr, mw, m2r, we, src, fbeq, fbne, fblt, fbge, fj, fjr};
  endfunction

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [31:0] fill;
    sh = b[4:0];
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    case (op)
      4'd1:    return a + ~b + 32'd1;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a * (32'd1 << sh);
      4'd6:    return a / (32'd1 << sh);
      4'd7:    return (a / (32'd1 << sh)) | fill;
      4'd8:    return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return b;
      default: return a + b;
    endcase
  endfunction

  // Pipeline model: what the EX/MEM register must show after each edge.
  always @(posedge clk) begin
    if (rst) exp_q.push_back('0);
    else exp_q.push_back({MR_in, MW_in, MemtoReg_in, jmp_in, regWE_in, rd_in,
                          alu_model(ex_alu_op, A, B), rout2_in, pc_in});
  end

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    logic [105:0] e;
    check("decode", dut_dec, dec_model(opcode, func3, func7, stall));
    check("alu", Result, alu_model(ex_alu_op, A, B));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("exmem", dut_pipe, e);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl_in(input logic [4:0] c, input logic [4:0] rd, input logic [31:0] r2, input logic [31:0] pc);
    {MR_in, MW_in, MemtoReg_in, jmp_in, regWE_in} = c;
    rd_in = rd; rout2_in = r2; pc_in = pc;
  endtask

  task automatic alu_lit(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    ex_alu_op = op; A = a; B = b;
    #1;
    check(name, Result, exp);
  endtask

  task automatic dec_lit(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic st, input logic [14:0] exp);
    opcode = op; func3 = f3; func7 = f7; stall = st;
    #1;
    check(name, dut_dec, exp);
  endtask

  initial begin
    logic [6:0] ops[10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    rst = 1'b1; opcode = 7'h03; func3 = 3'd2; func7 = 7'd0; stall = 1'b0;
    ex_alu_op = 4'd0; A = 32'd0; B = 32'd0;
    set_ctrl_in(5'b0, 5'd0, 32'd0, 32'd0);
    step();
    check("reset_state", dut_pipe, 106'd0);
    rst = 1'b0;

    // ALU literals
    alu_lit("alu_add_wrap", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
    alu_lit("alu_sub_neg", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
    alu_lit("alu_sra", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_lit("alu_srl", 4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000);
    alu_lit("alu_slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_lit("alu_sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_lit("alu_pass", 4'd10, 32'h1234, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Decoder literals
    dec_lit("dec_load", 7'h03, 3'd2, 7'd0, 1'b0, {4'd0, 5'b10111, 6'b000000});
    dec_lit("dec_store", 7'h23, 3'd2, 7'd0, 1'b0, {4'd0, 5'b01001, 6'b000000});
    dec_lit("dec_r_sub", 7'h33, 3'd0, 7'h20, 1'b0, {4'd1, 5'b00010, 6'b000000});
    dec_lit("dec_bneq", 7'h63, 3'd1, 7'd0, 1'b0, {4'd1, 5'b00000, 6'b010000});
    dec_lit("dec_bge", 7'h63, 3'd5, 7'd0, 1'b0, {4'd1, 5'b00000, 6'b000100});
    dec_lit("dec_br110", 7'h63, 3'd6, 7'd0, 1'b0, {4'd1, 5'b00000, 6'b000000});
    dec_lit("dec_jal", 7'h6F, 3'd0, 7'd0, 1'b0, {4'd0, 5'b00010, 6'b000010});
    dec_lit("dec_jalr", 7'h67, 3'd0, 7'd0, 1'b0, {4'd0, 5'b00011, 6'b000001});
    dec_lit("dec_stall", 7'h03, 3'd2, 7'd0, 1'b1, 15'd0);
    dec_lit("dec_unstall", 7'h03, 3'd2, 7'd0, 1'b0, {4'd0, 5'b10111, 6'b000000});

    // Pipeline latency and hold
    step();
    ex_alu_op = 4'd0; A = 32'd5; B = 32'd7;
    set_ctrl_in(5'b00001, 5'd3, 32'd0, 32'h10);
    step();
    check("pipe_result", alu_result_out, 32'd12);
    check("pipe_rd", rd_out, 5'd3);
    check("pipe_we", regWE_out, 1'b1);
    check("pipe_pc", pc_out, 32'h10);
    A = 32'd100; rd_in = 5'd9; pc_in = 32'h44;
    #2;
    check("pipe_hold", {alu_result_out, rd_out, pc_out}, {32'd12, 5'd3, 32'h10});

    // Reset with all inputs nonzero, then recapture
    ex_alu_op = 4'd0; A = 32'd3; B = 32'd4;
    set_ctrl_in(5'b11111, 5'h1F, 32'hAAAA, 32'h1234);
    rst = 1'b1;
    step();
    check("rst_clears", dut_pipe, 106'd0);
    rst = 1'b0;
    step();
    check("rst_recapture", dut_pipe, {5'b11111, 5'h1F, 32'd7, 32'hAAAA, 32'h1234});

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 29) == 0);
      opcode = ($urandom_range(0, 10) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      func3 = 3'($urandom);
      func7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
      stall = ($urandom_range(0, 7) == 0);
      ex_alu_op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      A = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      B = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      set_ctrl_in(5'($urandom), 5'($urandom), $urandom, $urandom);
      step();
    end
    rst = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
